// File: rtl/cpu_ctrl_pkg.sv
// Shared control-word layout, opcode encodings and sequencer state type for the 8-bit bus CPU.
// Consumers: control_microcode_rom, control_sequencer (optional feature macro: SINGLE_STEP_EN).
package cpu_ctrl_pkg;

  localparam int CTRL_W = 16;

  localparam int HLT_BIT      = 15;
  localparam int MAR_IN_BIT   = 14;
  localparam int RAM_IN_BIT   = 13;
  localparam int RAM_OUT_BIT  = 12;
  localparam int IR_OUT_BIT   = 11;
  localparam int IR_IN_BIT    = 10;
  localparam int A_IN_BIT     = 9;
  localparam int A_OUT_BIT    = 8;
  localparam int ALU_OUT_BIT  = 7;
  localparam int ALU_SUB_BIT  = 6;
  localparam int B_IN_BIT     = 5;
  localparam int OUT_IN_BIT   = 4;
  localparam int PC_INC_BIT   = 3;
  localparam int PC_OUT_BIT   = 2;
  localparam int PC_LOAD_BIT  = 1;
  localparam int FLAGS_IN_BIT = 0;

  localparam logic [CTRL_W-1:0] HLT      = CTRL_W'(1) << HLT_BIT;
  localparam logic [CTRL_W-1:0] MAR_IN   = CTRL_W'(1) << MAR_IN_BIT;
  localparam logic [CTRL_W-1:0] RAM_IN   = CTRL_W'(1) << RAM_IN_BIT;
  localparam logic [CTRL_W-1:0] RAM_OUT  = CTRL_W'(1) << RAM_OUT_BIT;
  localparam logic [CTRL_W-1:0] IR_OUT   = CTRL_W'(1) << IR_OUT_BIT;
  localparam logic [CTRL_W-1:0] IR_IN    = CTRL_W'(1) << IR_IN_BIT;
  localparam logic [CTRL_W-1:0] A_IN     = CTRL_W'(1) << A_IN_BIT;
  localparam logic [CTRL_W-1:0] A_OUT    = CTRL_W'(1) << A_OUT_BIT;
  localparam logic [CTRL_W-1:0] ALU_OUT  = CTRL_W'(1) << ALU_OUT_BIT;
  localparam logic [CTRL_W-1:0] ALU_SUB  = CTRL_W'(1) << ALU_SUB_BIT;
  localparam logic [CTRL_W-1:0] B_IN     = CTRL_W'(1) << B_IN_BIT;
  localparam logic [CTRL_W-1:0] OUT_IN   = CTRL_W'(1) << OUT_IN_BIT;
  localparam logic [CTRL_W-1:0] PC_INC   = CTRL_W'(1) << PC_INC_BIT;
  localparam logic [CTRL_W-1:0] PC_OUT   = CTRL_W'(1) << PC_OUT_BIT;
  localparam logic [CTRL_W-1:0] PC_LOAD  = CTRL_W'(1) << PC_LOAD_BIT;
  localparam logic [CTRL_W-1:0] FLAGS_IN = CTRL_W'(1) << FLAGS_IN_BIT;

  // Strobes that change register contents; masked while a single-step request is absent.
  localparam logic [CTRL_W-1:0] LATCH_MASK = MAR_IN | RAM_IN | IR_IN | A_IN | B_IN |
                                             OUT_IN | PC_INC | PC_LOAD | FLAGS_IN;

  localparam logic [2:0] LAST_STEP = 3'd4;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/control_microcode_rom.sv
// Combinational microcode table: (opcode, step, flags) -> control word plus last-step marker.
module control_microcode_rom
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0]        opcode,
  input  logic [2:0]        step,
  input  logic              carry,
  input  logic              zero,
  output logic [CTRL_W-1:0] ctrl_word,
  output logic              last
);

  always_comb begin
    ctrl_word = '0;
    last      = 1'b0;
    case (step)
      3'd0: ctrl_word = PC_OUT | MAR_IN;
      3'd1: begin
        ctrl_word = RAM_OUT | IR_IN | PC_INC;
        // Only opcodes with an execute phase continue past T1; undefined ones fall out here.
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
          OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last = 1'b0;
          default:                              last = 1'b1;
        endcase
      end
      3'd2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl_word = IR_OUT | MAR_IN;
          OP_LDI: begin ctrl_word = IR_OUT | A_IN;    last = 1'b1; end
          OP_JMP: begin ctrl_word = IR_OUT | PC_LOAD; last = 1'b1; end
          OP_JC: begin
            ctrl_word = carry ? (IR_OUT | PC_LOAD) : '0;
            last      = 1'b1;
          end
          OP_JZ: begin
            ctrl_word = zero ? (IR_OUT | PC_LOAD) : '0;
            last      = 1'b1;
          end
          OP_OUT: begin ctrl_word = A_OUT | OUT_IN; last = 1'b1; end
          OP_HLT: begin ctrl_word = HLT;            last = 1'b1; end
          default: last = 1'b1;
        endcase
      end
      3'd3: begin
        case (opcode)
          OP_LDA:         begin ctrl_word = RAM_OUT | A_IN;  last = 1'b1; end
          OP_ADD, OP_SUB: ctrl_word = RAM_OUT | B_IN;
          OP_STA:         begin ctrl_word = A_OUT | RAM_IN;  last = 1'b1; end
          default:        last = 1'b1;
        endcase
      end
      LAST_STEP: begin
        last = 1'b1;
        case (opcode)
          OP_ADD:  ctrl_word = ALU_OUT | A_IN | FLAGS_IN;
          OP_SUB:  ctrl_word = ALU_OUT | A_IN | FLAGS_IN | ALU_SUB;
          default: ctrl_word = '0;
        endcase
      end
      // Unreachable step values recover to fetch on the next advance.
      default: last = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// T-state sequencer for the 8-bit bus CPU: step counter, halt state, reset forcing of ctrl.
// Optional macro SINGLE_STEP_EN adds step_req, gating advances and masking latch strobes.
module control_sequencer #(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 3,
  parameter int CTRL_W   = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                carry_flag,
  input  logic                zero_flag,
`ifdef SINGLE_STEP_EN
  input  logic                step_req,
`endif
  output logic [CTRL_W-1:0]   ctrl,
  output logic [STEP_W-1:0]   step,
  output logic                halted
);
  import cpu_ctrl_pkg::*;

  seq_state_e          state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [CTRL_W-1:0]   rom_ctrl;
  logic                rom_last;
  logic                advance;
  logic [CTRL_W-1:0]   ctrl_run;

  control_microcode_rom u_rom (
    .opcode    (opcode),
    .step      (step_q),
    .carry     (carry_flag),
    .zero      (zero_flag),
    .ctrl_word (rom_ctrl),
    .last      (rom_last)
  );

`ifdef SINGLE_STEP_EN
  assign advance = step_req;
`else
  assign advance = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    ctrl_run = rom_ctrl;
    case (state_q)
      ST_RUN: begin
        if (advance) begin
          if (rom_last) begin
            step_d = '0;
            if (opcode == OPCODE_W'(OP_HLT) && step_q == STEP_W'(2))
              state_d = ST_HALT;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      ST_HALT: ctrl_run = HLT;
      default: state_d = ST_RUN;
    endcase
    if (!advance)
      ctrl_run = ctrl_run & ~LATCH_MASK;
  end

  // Reset forces a quiet bus immediately, independent of the clock.
  assign ctrl   = reset_n ? ctrl_run : '0;
  assign step   = step_q;
  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; single-step checks build with SINGLE_STEP_EN.
module tb_control_sequencer;

  localparam logic [15:0] F_T0     = 16'h4004; // PC_OUT|MAR_IN
  localparam logic [15:0] F_T1     = 16'h1408; // RAM_OUT|IR_IN|PC_INC
  localparam logic [15:0] IRO_MAR  = 16'h4800;
  localparam logic [15:0] RAMO_BIN = 16'h1020;
  localparam logic [15:0] ADD_T4   = 16'h0281;
  localparam logic [15:0] SUB_T4   = 16'h02C1;
  localparam logic [15:0] RAMO_AIN = 16'h1200;
  localparam logic [15:0] AO_RAMI  = 16'h2100;
  localparam logic [15:0] IRO_AIN  = 16'h0A00;
  localparam logic [15:0] IRO_PCL  = 16'h0802;
  localparam logic [15:0] AO_OUTI  = 16'h0110;
  localparam logic [15:0] HLT_W    = 16'h8000;

  logic        clk;
  logic        reset_n;
  logic [3:0]  opcode;
  logic        carry_flag;
  logic        zero_flag;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        halted;
`ifdef SINGLE_STEP_EN
  logic        step_req;
`endif

  int checks = 0;
  int errors = 0;

  control_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
`ifdef SINGLE_STEP_EN
    .step_req   (step_req),
`endif
    .ctrl       (ctrl),
    .step       (step),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from T0 (step must be 0 and a posedge must be next); n = total steps.
  task automatic exec(input string tag, input logic [3:0] op, input int n,
                      input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4);
    logic [15:0] ex [5];
    ex = '{F_T0, F_T1, e2, e3, e4};
    opcode = op;
    for (int s = 0; s < n; s++) begin
      #1;
      check($sformatf("%s T%0d ctrl", tag, s), ctrl, ex[s]);
      check($sformatf("%s T%0d step", tag, s), {13'd0, step}, 16'(s));
      tick();
    end
    check($sformatf("%s wrap step", tag), {13'd0, step}, 16'd0);
    $display("txn %s opcode=%h steps=%0d done", tag, op, n);
  endtask

  initial begin
    reset_n    = 1'b0;
    opcode     = 4'h2;
    carry_flag = 1'b0;
    zero_flag  = 1'b0;
`ifdef SINGLE_STEP_EN
    step_req   = 1'b1;
`endif
    #1;
    check("reset ctrl", ctrl, 16'h0000);
    check("reset step", {13'd0, step}, 16'd0);
    check("reset halted", {15'd0, halted}, 16'd0);
    tick();
    tick();
    check("reset hold step", {13'd0, step}, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;

    exec("ADD", 4'h2, 5, IRO_MAR, RAMO_BIN, ADD_T4);
    exec("SUB", 4'h3, 5, IRO_MAR, RAMO_BIN, SUB_T4);

    // Reset in the middle of ADD at T3
    opcode = 4'h2;
    tick(); tick(); tick();
    check("midADD step before reset", {13'd0, step}, 16'd3);
    reset_n = 1'b0;
    #1;
    check("midADD reset ctrl", ctrl, 16'h0000);
    check("midADD reset step", {13'd0, step}, 16'd0);
    tick();
    check("midADD reset held ctrl", ctrl, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    exec("ADD after reset", 4'h2, 5, IRO_MAR, RAMO_BIN, ADD_T4);

    exec("LDA", 4'h1, 4, IRO_MAR, RAMO_AIN, 16'h0);
    exec("STA", 4'h4, 4, IRO_MAR, AO_RAMI, 16'h0);
    exec("LDI", 4'h5, 3, IRO_AIN, 16'h0, 16'h0);
    exec("JMP", 4'h6, 3, IRO_PCL, 16'h0, 16'h0);
    carry_flag = 1'b0;
    exec("JC c0", 4'h7, 3, 16'h0000, 16'h0, 16'h0);
    carry_flag = 1'b1;
    exec("JC c1", 4'h7, 3, IRO_PCL, 16'h0, 16'h0);
    carry_flag = 1'b0;
    zero_flag = 1'b1;
    exec("JZ z1", 4'h8, 3, IRO_PCL, 16'h0, 16'h0);
    zero_flag = 1'b0;
    exec("JZ z0", 4'h8, 3, 16'h0000, 16'h0, 16'h0);
    exec("OUT", 4'hE, 3, AO_OUTI, 16'h0, 16'h0);
    exec("NOP", 4'h0, 2, 16'h0, 16'h0, 16'h0);
    exec("undef 0xB", 4'hB, 2, 16'h0, 16'h0, 16'h0);
    exec("undef 0x9", 4'h9, 2, 16'h0, 16'h0, 16'h0);

    // Flag changing during T2 affects that cycle's decode only
    opcode = 4'h8;
    tick(); tick();
    check("JZ flip step", {13'd0, step}, 16'd2);
    check("JZ flip z0 ctrl", ctrl, 16'h0000);
    zero_flag = 1'b1;
    #1;
    check("JZ flip z1 ctrl", ctrl, IRO_PCL);
    tick();
    zero_flag = 1'b0;
    check("JZ flip wrap step", {13'd0, step}, 16'd0);
    $display("txn JZ flag flip done");

`ifdef SINGLE_STEP_EN
    opcode = 4'h1;
    tick();
    step_req = 1'b0;
    #1;
    check("ss T1 masked ctrl", ctrl, 16'h1000);
    for (int i = 0; i < 5; i++) tick();
    check("ss hold step", {13'd0, step}, 16'd1);
    check("ss hold ctrl", ctrl, 16'h1000);
    step_req = 1'b1;
    #1;
    check("ss req ctrl", ctrl, F_T1);
    tick();
    step_req = 1'b0;
    check("ss pulse step", {13'd0, step}, 16'd2);
    check("ss T2 masked ctrl", ctrl, 16'h0800);
    tick();
    check("ss T2 hold step", {13'd0, step}, 16'd2);
    step_req = 1'b1;
    tick(); tick();
    check("ss LDA wrap step", {13'd0, step}, 16'd0);
    $display("txn single-step LDA done");
`endif

    // HLT: halted one cycle after T2, then frozen
    opcode = 4'hF;
    tick(); tick();
    check("HLT T2 ctrl", ctrl, HLT_W);
    check("HLT T2 halted", {15'd0, halted}, 16'd0);
    tick();
    opcode = 4'h2;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("halted c%0d", i), {15'd0, halted}, 16'd1);
      check($sformatf("halted step c%0d", i), {13'd0, step}, 16'd0);
      check($sformatf("halted ctrl c%0d", i), ctrl, HLT_W);
      tick();
    end
    $display("txn HLT done");
    reset_n = 1'b0;
    #1;
    check("unhalt reset halted", {15'd0, halted}, 16'd0);
    check("unhalt reset ctrl", ctrl, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    exec("NOP after halt", 4'h0, 2, 16'h0, 16'h0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
